y86_decode_regfile: RTL and testbench
=====================================

// Module: y86_decode_regfile
// PURPOSE
//  Parametrised Y86-64 decode stage: derives srcA/srcB/dstE/dstM from icode/rA/rB, reads a
//  2-write/2-read register file, latches results into a stallable D->E pipeline register.
//  Successor to the SEQ decode: owns register state and writeback, adds stall/bubble/halt.
// PARAMETERS
//  DATA_W   64  register and valA/valB width
//  NUM_REGS 15  implemented registers (ids 0..NUM_REGS-1); id 4'hF = RNONE, never stored
//  RSP_ID   4   stack-pointer register id
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       decode inputs hold a real instruction
//  icode      in   4       instruction code
//  rA, rB     in   4       register specifiers from fetch
//  stall      in   1       hold D->E register
//  bubble     in   1       load nop into D->E register
//  wE_en      in   1       write port E enable
//  wE_dst     in   4       write port E register id
//  wE_data    in   DATA_W  write port E data
//  wM_en, wM_dst, wM_data  write port M (same widths as E)
//  e_valid    out  1       D->E register holds a real instruction
//  e_icode    out  4       registered icode
//  e_valA     out  DATA_W  registered read A
//  e_valB     out  DATA_W  registered read B
//  e_srcA, e_srcB, e_dstE, e_dstM  out 4  registered register ids
//  e_stat     out  2       0 AOK, 1 HLT, 2 INS
//  halted     out  1       sticky, set once halt enters D->E
// BEHAVIOUR
//  Id selection (combinational, out-of-set -> RNONE):
//   srcA: 2,4,6,A -> rA; 9,B -> RSP_ID.  srcB: 4,5,6 -> rB; 8,9,A,B -> RSP_ID.
//   dstE: 2,3,6 -> rB; 8,9,A,B -> RSP_ID.  dstM: 5,B -> rA.
//  Read: combinational; RNONE or id >= NUM_REGS reads 0.
//  Write: posedge; en=0, RNONE or id >= NUM_REGS ignored; same id on E and M -> M wins.
//  D->E register, 1-cycle latency; priority reset > halted > stall > bubble > load:
//   reset: e_icode=1 (nop), ids=F, vals=0, e_valid=0, e_stat=AOK, halted=0, regs all 0.
//   halted: e_valid forced 0, other fields hold; register-file writes still accepted.
//   stall: hold all fields (stall+bubble together -> stall).
//   bubble or in_valid=0: nop image as at reset.
//   load: capture icode, ids, reads; e_valid=1; e_stat = HLT if icode 0, INS if icode > 4'hB
//    (ids forced F, vals 0 for INS), else AOK. halted sets on the cycle HLT is loaded.
//  Reset mid-stall or mid-write: async clear wins immediately; no partial write committed.
// CONFIGURATION
//  WB_BYPASS_EN defined: read of id written the same cycle returns write data (M over E).
//  Not defined: read returns pre-write value; forwarding left to the hazard unit.
// STRUCTURE
//  y86_pkg: icode constants (I_HALT..I_POPQ), RNONE=4'hF, STAT_AOK/HLT/INS, nop image.
//  Sub-module y86_regfile: storage, 2W/2R, M-priority, optional bypass; top holds id
//  selection, D->E register, halt/status logic.
// TESTING
//  rst_n low, then regs preloaded via wE/wM: icode=6,rA=1,rB=2 (r1=A61,r2=9F) -> next
//   cycle e_valA=A61, e_valB=9F, e_dstE=2, e_dstM=F, e_valid=1.
//  icode=B,rA=3, r4=A1BC -> e_srcA=4, e_srcB=4, e_dstE=4, e_dstM=3, e_valA=e_valB=A1BC.
//  wE_dst=wM_dst=4, wE=11, wM=22 same cycle -> r4=22; with WB_BYPASS_EN a same-cycle read
//   of r4 gives 22, without it gives old value.
//  stall=1 and bubble=1 for 2 cycles while inputs change -> outputs unchanged; bubble alone
//   -> e_icode=1, ids F, e_valid=0.
//  icode=0 loaded -> e_stat=HLT, halted=1; later icode=6 -> e_valid stays 0 until rst_n.
//  icode=C -> e_stat=INS, ids F, vals 0; rst_n pulsed mid-stall -> all outputs at reset values.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode constants, status codes and the D->E nop image.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {STAT_AOK = 2'd0, STAT_HLT = 2'd1, STAT_INS = 2'd2} stat_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] icode;
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
        stat_e      stat;
    } de_t;

    localparam de_t NOP_DE = '{valid: 1'b0, icode: I_NOP, src_a: RNONE, src_b: RNONE,
                               dst_e: RNONE, dst_m: RNONE, stat: STAT_AOK};
endpackage

// File: rtl/y86_decode_regfile_if.sv
// y86_decode_regfile_if: decode inputs, writeback ports and D->E outputs of the decode stage.
interface y86_decode_regfile_if #(parameter int DATA_W = 64);
    logic              in_valid;
    logic [3:0]        icode, rA, rB;
    logic              stall, bubble;
    logic              wE_en, wM_en;
    logic [3:0]        wE_dst, wM_dst;
    logic [DATA_W-1:0] wE_data, wM_data;
    logic              e_valid;
    logic [3:0]        e_icode, e_srcA, e_srcB, e_dstE, e_dstM;
    logic [DATA_W-1:0] e_valA, e_valB;
    logic [1:0]        e_stat;
    logic              halted;

    modport master (
        output in_valid, icode, rA, rB, stall, bubble,
               wE_en, wE_dst, wE_data, wM_en, wM_dst, wM_data,
        input  e_valid, e_icode, e_valA, e_valB, e_srcA, e_srcB, e_dstE, e_dstM, e_stat, halted
    );
    modport slave (
        input  in_valid, icode, rA, rB, stall, bubble,
               wE_en, wE_dst, wE_data, wM_en, wM_dst, wM_data,
        output e_valid, e_icode, e_valA, e_valB, e_srcA, e_srcB, e_dstE, e_dstM, e_stat, halted
    );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: 2-write/2-read register file, M port wins on a shared id.
// WB_BYPASS_EN: same-cycle writes are forwarded onto the read ports.
module y86_regfile import y86_pkg::*; #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_e,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] data_e,
    input  logic              we_m,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] data_m,
    input  logic [3:0]        ra_id,
    input  logic [3:0]        rb_id,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              e_hit, m_hit, legal_a, legal_b;
    logic [DATA_W-1:0] base_a, base_b;

    assign e_hit   = we_e && dst_e != RNONE && int'(dst_e) < NUM_REGS;
    assign m_hit   = we_m && dst_m != RNONE && int'(dst_m) < NUM_REGS;
    assign legal_a = ra_id != RNONE && int'(ra_id) < NUM_REGS;
    assign legal_b = rb_id != RNONE && int'(rb_id) < NUM_REGS;
    assign base_a  = legal_a ? regs_q[ra_id] : '0;
    assign base_b  = legal_b ? regs_q[rb_id] : '0;

`ifdef WB_BYPASS_EN
    assign rd_a = (m_hit && dst_m == ra_id) ? data_m : (e_hit && dst_e == ra_id) ? data_e : base_a;
    assign rd_b = (m_hit && dst_m == rb_id) ? data_m : (e_hit && dst_e == rb_id) ? data_e : base_b;
`else
    assign rd_a = base_a;
    assign rd_b = base_b;
`endif

    // M is applied last so it overrides E on a shared destination
    always_comb begin
        regs_d = regs_q;
        if (e_hit) regs_d[dst_e] = data_e;
        if (m_hit) regs_d[dst_m] = data_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end
endmodule

// File: rtl/y86_decode_regfile.sv
// y86_decode_regfile: Y86-64 decode stage with register file and stallable D->E register.
// WB_BYPASS_EN (optional): forwards same-cycle writeback data to the decode reads.
module y86_decode_regfile import y86_pkg::*; #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int RSP_ID   = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    y86_decode_regfile_if.slave  bus
);
    localparam logic [3:0] RSP = 4'(RSP_ID);

    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rd_a, rd_b;
    stat_e             ld_stat;
    de_t               de_q, de_d;
    logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
    logic              halted_q, halted_d, ins;

    assign src_a = (bus.icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? bus.rA :
                   (bus.icode inside {I_RET, I_POPQ}) ? RSP : RNONE;
    assign src_b = (bus.icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? bus.rB :
                   (bus.icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP : RNONE;
    assign dst_e = (bus.icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ}) ? bus.rB :
                   (bus.icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP : RNONE;
    assign dst_m = (bus.icode inside {I_MRMOVQ, I_POPQ}) ? bus.rA : RNONE;

    assign ld_stat = bus.icode == I_HALT ? STAT_HLT : bus.icode > I_POPQ ? STAT_INS : STAT_AOK;
    assign ins     = ld_stat == STAT_INS;

    y86_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (bus.wE_en),
        .dst_e  (bus.wE_dst),
        .data_e (bus.wE_data),
        .we_m   (bus.wM_en),
        .dst_m  (bus.wM_dst),
        .data_m (bus.wM_data),
        .ra_id  (src_a),
        .rb_id  (src_b),
        .rd_a   (rd_a),
        .rd_b   (rd_b)
    );

    // priority: halted > stall > bubble/empty slot > load
    always_comb begin
        de_d     = de_q;
        val_a_d  = val_a_q;
        val_b_d  = val_b_q;
        halted_d = halted_q;
        if (halted_q) begin
            de_d.valid = 1'b0;
        end else if (!bus.stall) begin
            if (bus.bubble || !bus.in_valid) begin
                de_d    = NOP_DE;
                val_a_d = '0;
                val_b_d = '0;
            end else begin
                de_d     = '{valid: 1'b1, icode: bus.icode, src_a: ins ? RNONE : src_a,
                             src_b: ins ? RNONE : src_b, dst_e: ins ? RNONE : dst_e,
                             dst_m: ins ? RNONE : dst_m, stat: ld_stat};
                val_a_d  = ins ? '0 : rd_a;
                val_b_d  = ins ? '0 : rd_b;
                halted_d = ld_stat == STAT_HLT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q     <= NOP_DE;
            val_a_q  <= '0;
            val_b_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            de_q     <= de_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            halted_q <= halted_d;
        end
    end

    assign bus.e_valid = de_q.valid;
    assign bus.e_icode = de_q.icode;
    assign bus.e_srcA  = de_q.src_a;
    assign bus.e_srcB  = de_q.src_b;
    assign bus.e_dstE  = de_q.dst_e;
    assign bus.e_dstM  = de_q.dst_m;
    assign bus.e_stat  = de_q.stat;
    assign bus.e_valA  = val_a_q;
    assign bus.e_valB  = val_b_q;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_y86_decode_regfile.sv
// tb_y86_decode_regfile: directed and random decode traffic checked against a behavioural model.
module tb_y86_decode_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    y86_decode_regfile_if #(.DATA_W(64)) bus ();
    y86_decode_regfile #(.DATA_W(64), .NUM_REGS(15), .RSP_ID(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [63:0] mregs [16];
    logic        m_valid, m_halted;
    logic [3:0]  m_icode, m_sa, m_sb, m_de, m_dm;
    logic [63:0] m_va, m_vb;
    logic [1:0]  m_stat;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(string ctx);
        check({ctx, ".valid"},  64'(bus.e_valid), 64'(m_valid));
        check({ctx, ".icode"},  64'(bus.e_icode), 64'(m_icode));
        check({ctx, ".valA"},   bus.e_valA, m_va);
        check({ctx, ".valB"},   bus.e_valB, m_vb);
        check({ctx, ".srcA"},   64'(bus.e_srcA), 64'(m_sa));
        check({ctx, ".srcB"},   64'(bus.e_srcB), 64'(m_sb));
        check({ctx, ".dstE"},   64'(bus.e_dstE), 64'(m_de));
        check({ctx, ".dstM"},   64'(bus.e_dstM), 64'(m_dm));
        check({ctx, ".stat"},   64'(bus.e_stat), 64'(m_stat));
        check({ctx, ".halted"}, 64'(bus.halted), 64'(m_halted));
    endtask

    function automatic logic [3:0] f_srca(logic [3:0] ic, logic [3:0] ra);
        case (ic)
            4'h2, 4'h4, 4'h6, 4'hA: return ra;
            4'h9, 4'hB:             return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] f_srcb(logic [3:0] ic, logic [3:0] rb);
        case (ic)
            4'h4, 4'h5, 4'h6:       return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] f_dste(logic [3:0] ic, logic [3:0] rb);
        case (ic)
            4'h2, 4'h3, 4'h6:       return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] f_dstm(logic [3:0] ic, logic [3:0] ra);
        return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] rdv(logic [3:0] id);
        logic [63:0] v;
        v = (id < 4'd15) ? mregs[id] : 64'd0;
`ifdef WB_BYPASS_EN
        if (bus.wE_en && bus.wE_dst == id && id < 4'd15) v = bus.wE_data;
        if (bus.wM_en && bus.wM_dst == id && id < 4'd15) v = bus.wM_data;
`endif
        return v;
    endfunction

    task automatic model_nop();
        m_valid = 0; m_icode = 4'h1; m_sa = 4'hF; m_sb = 4'hF; m_de = 4'hF; m_dm = 4'hF;
        m_va = 0; m_vb = 0; m_stat = 2'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 64'd0;
        model_nop();
        m_halted = 0;
    endtask

    task automatic model_step();
        logic [3:0] ic;
        ic = bus.icode;
        if (m_halted) m_valid = 0;
        else if (!bus.stall) begin
            if (bus.bubble || !bus.in_valid) model_nop();
            else if (ic > 4'hB) begin
                model_nop();
                m_valid = 1; m_icode = ic; m_stat = 2'd2;
            end else begin
                m_valid = 1; m_icode = ic;
                m_sa = f_srca(ic, bus.rA); m_sb = f_srcb(ic, bus.rB);
                m_de = f_dste(ic, bus.rB); m_dm = f_dstm(ic, bus.rA);
                m_va = rdv(m_sa); m_vb = rdv(m_sb);
                m_stat = (ic == 4'h0) ? 2'd1 : 2'd0;
                m_halted = (ic == 4'h0);
            end
        end
        if (bus.wE_en && bus.wE_dst < 4'd15) mregs[bus.wE_dst] = bus.wE_data;
        if (bus.wM_en && bus.wM_dst < 4'd15) mregs[bus.wM_dst] = bus.wM_data;
    endtask

    task automatic set_idle();
        bus.in_valid = 0; bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF;
        bus.stall = 0; bus.bubble = 0;
        bus.wE_en = 0; bus.wE_dst = 4'hF; bus.wE_data = 0;
        bus.wM_en = 0; bus.wM_dst = 4'hF; bus.wM_data = 0;
    endtask

    task automatic step(string ctx);
        model_step();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic randomize_inputs(bit allow_halt);
        bus.in_valid = ($urandom_range(0, 7) != 0);
        bus.icode    = allow_halt ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
        bus.rA       = 4'($urandom_range(0, 15));
        bus.rB       = 4'($urandom_range(0, 15));
        bus.stall    = ($urandom_range(0, 3) == 0);
        bus.bubble   = ($urandom_range(0, 3) == 0);
        bus.wE_en    = $urandom_range(0, 1);
        bus.wE_dst   = 4'($urandom_range(0, 15));
        bus.wE_data  = {$urandom, $urandom};
        bus.wM_en    = $urandom_range(0, 1);
        bus.wM_dst   = ($urandom_range(0, 3) == 0) ? bus.wE_dst : 4'($urandom_range(0, 15));
        bus.wM_data  = {$urandom, $urandom};
    endtask

    initial begin
        set_idle();
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1;

        bus.wE_en = 1; bus.wE_dst = 1; bus.wE_data = 64'hA61;
        bus.wM_en = 1; bus.wM_dst = 2; bus.wM_data = 64'h9F;
        step("preload");
        set_idle();
        bus.in_valid = 1; bus.icode = 4'h6; bus.rA = 1; bus.rB = 2;
        step("opq");
        check("opq_valA", bus.e_valA, 64'hA61);
        check("opq_valB", bus.e_valB, 64'h9F);
        check("opq_dstE", 64'(bus.e_dstE), 64'd2);

        set_idle();
        bus.wE_en = 1; bus.wE_dst = 4; bus.wE_data = 64'hA1BC;
        step("wr_r4");
        set_idle();
        bus.in_valid = 1; bus.icode = 4'hB; bus.rA = 3;
        step("popq");
        check("popq_dstM", 64'(bus.e_dstM), 64'd3);
        check("popq_valB", bus.e_valB, 64'hA1BC);

        set_idle();
        bus.in_valid = 1; bus.icode = 4'h6; bus.rA = 4; bus.rB = 4;
        bus.wE_en = 1; bus.wE_dst = 4; bus.wE_data = 64'h11;
        bus.wM_en = 1; bus.wM_dst = 4; bus.wM_data = 64'h22;
        step("same_cycle_wr");
`ifdef WB_BYPASS_EN
        check("bypass_valA", bus.e_valA, 64'h22);
`else
        check("nobypass_valA", bus.e_valA, 64'hA1BC);
`endif
        set_idle();
        bus.in_valid = 1; bus.icode = 4'h6; bus.rA = 4; bus.rB = 5;
        step("m_wins");
        check("m_wins_valA", bus.e_valA, 64'h22);

        for (int i = 0; i < 2; i++) begin
            randomize_inputs(0);
            bus.stall = 1; bus.bubble = 1;
            step("stall_bubble");
        end
        check("stall_hold_valA", bus.e_valA, 64'h22);
        set_idle();
        bus.in_valid = 1; bus.icode = 4'h6; bus.bubble = 1;
        step("bubble");
        check("bubble_icode", 64'(bus.e_icode), 64'd1);

        set_idle();
        bus.in_valid = 1; bus.icode = 4'hC; bus.rA = 1; bus.rB = 2;
        step("ins");
        check("ins_stat", 64'(bus.e_stat), 64'd2);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs(0);
            step("rand");
        end

        set_idle();
        bus.in_valid = 1; bus.icode = 4'h0;
        step("halt");
        check("halt_flag", 64'(bus.halted), 64'd1);
        for (int i = 0; i < 20; i++) begin
            randomize_inputs(1);
            bus.in_valid = 1; bus.icode = 4'h6; bus.stall = 0; bus.bubble = 0;
            step("halted");
        end

        set_idle();
        bus.stall = 1;
        bus.wE_en = 1; bus.wE_dst = 3; bus.wE_data = 64'hFF;
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #3;
        rst_n = 1;
        set_idle();
        bus.in_valid = 1; bus.icode = 4'h6; bus.rA = 3; bus.rB = 1;
        step("post_rst");
        check("post_rst_r3", bus.e_valA, 64'd0);

        for (int i = 0; i < 300; i++) begin
            randomize_inputs(1);
            step("rand2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
